// File: rtl/hive_irq_router.sv
// Routes edge-detected interrupt sources to per-thread xsr pulses with round-robin arbitration and per-thread service FSMs.
// Latency: src rise on cycle n gives xsr on n+2. A busy thread holds its sources pending until it returns to IDLE.
module hive_irq_router #(
    parameter int SRCS        = 16,
    parameter int THREADS     = 8,
    parameter int ID_W        = 3,
    parameter int SRC_W       = 4,
    parameter int TMO_W       = 12,
    parameter int RBUS_ADDR_W = 8,
    parameter int ALU_W       = 32,
    parameter logic [RBUS_ADDR_W-1:0] ADDR = 8'h20
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [SRCS-1:0]        src_i,
    output logic [THREADS-1:0]     xsr_o,
    output logic [SRCS-1:0]        ovf_o,
    output logic [THREADS-1:0]     tmo_o,
    input  logic [ID_W-1:0]        id_i,
    input  logic                   clt_i,
    input  logic                   irt_i,
    input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
    input  logic                   rbus_wr_i,
    input  logic                   rbus_rd_i,
    input  logic [ALU_W-1:0]       rbus_wr_data_i,
    output logic [ALU_W-1:0]       rbus_rd_data_o
);

    localparam logic [RBUS_ADDR_W-1:0] ADDR_MAP = ADDR + 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ISSUE = 3'b010,
        S_WAIT  = 3'b100
    } state_t;

    logic [SRCS-1:0]    src_q, en_q, pend_q, ovf_q;
    logic [SRCS-1:0]    rise, grant_vec, en_nxt;
    logic [ID_W-1:0]    map_q [SRCS];
    logic [SRC_W-1:0]   rr_q [THREADS];
    logic [SRC_W-1:0]   gnt_src [THREADS];
    logic [THREADS-1:0] gnt_vld, take, rel, clr, xsr, tmo;
    state_t             state_q [THREADS];
    state_t             state_d [THREADS];
    logic [TMO_W-1:0]   tmr_q [THREADS];
    logic [TMO_W-1:0]   tmr_d [THREADS];
    logic               wr_en, wr_map;
    logic               wr_data_unused;

    assign rise           = src_i & ~src_q;
    assign wr_en          = rbus_wr_i && (rbus_addr_i == ADDR);
    assign wr_map         = rbus_wr_i && (rbus_addr_i == ADDR_MAP);
    assign en_nxt         = wr_en ? rbus_wr_data_i[SRCS-1:0] : en_q;
    assign wr_data_unused = ^rbus_wr_data_i;

    assign xsr_o = xsr;
    assign tmo_o = tmo;
    assign ovf_o = ovf_q;

    always_comb begin
        rbus_rd_data_o = '0;
        if (rbus_rd_i) begin
            if (rbus_addr_i == ADDR)
                rbus_rd_data_o = ALU_W'(en_q);
            else if (rbus_addr_i == ADDR_MAP)
                rbus_rd_data_o = ALU_W'(pend_q);
        end
    end

    always_comb begin
        rel = '0;
        clr = '0;
        for (int t = 0; t < THREADS; t++) begin
            rel[t] = (irt_i | clt_i) && (id_i == ID_W'(t));
            clr[t] = clt_i && (id_i == ID_W'(t));
        end
    end

    // Per-thread search starts at rr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        gnt_vld = '0;
        for (int t = 0; t < THREADS; t++) begin
            gnt_src[t] = '0;
            for (int i = 0; i < SRCS; i++) begin
                int idx;
                logic [SRC_W-1:0] sidx;
                idx = int'(rr_q[t]) + i;
                if (idx >= SRCS)
                    idx = idx - SRCS;
                sidx = SRC_W'(idx);
                if (!gnt_vld[t] && pend_q[sidx] && (map_q[sidx] == ID_W'(t))) begin
                    gnt_vld[t] = 1'b1;
                    gnt_src[t] = sidx;
                end
            end
        end
    end

    always_comb begin
        grant_vec = '0;
        take      = '0;
        xsr       = '0;
        tmo       = '0;
        for (int t = 0; t < THREADS; t++) begin
            state_d[t] = state_q[t];
            tmr_d[t]   = tmr_q[t];
            case (state_q[t])
                S_IDLE: begin
                    if (gnt_vld[t] && !clr[t]) begin
                        state_d[t]            = S_ISSUE;
                        take[t]               = 1'b1;
                        grant_vec[gnt_src[t]] = 1'b1;
                    end
                end
                S_ISSUE: begin
                    xsr[t]     = 1'b1;
                    state_d[t] = S_WAIT;
                    tmr_d[t]   = '1;
                end
                S_WAIT: begin
                    if (rel[t]) begin
                        state_d[t] = S_IDLE;
                    end else if (tmr_q[t] == '0) begin
                        tmo[t]     = 1'b1;
                        state_d[t] = S_IDLE;
                    end else begin
                        tmr_d[t] = tmr_q[t] - 1'b1;
                    end
                end
                default: state_d[t] = S_IDLE;
            endcase
            if (clr[t])
                state_d[t] = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < THREADS; t++) begin
                state_q[t] <= S_IDLE;
                tmr_q[t]   <= '0;
                rr_q[t]    <= '0;
            end
        end else begin
            for (int t = 0; t < THREADS; t++) begin
                state_q[t] <= state_d[t];
                tmr_q[t]   <= tmr_d[t];
                if (take[t])
                    rr_q[t] <= (gnt_src[t] == SRC_W'(SRCS - 1)) ? '0 : gnt_src[t] + 1'b1;
            end
        end
    end

    // A rise coinciding with its own grant re-arms pend instead of counting as overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q  <= '0;
            en_q   <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
            for (int s = 0; s < SRCS; s++)
                map_q[s] <= ID_W'(s % THREADS);
        end else begin
            src_q  <= src_i;
            en_q   <= en_nxt;
            pend_q <= ((pend_q & ~grant_vec) | (rise & en_q)) & en_nxt;
            ovf_q  <= rise & en_q & pend_q & ~grant_vec;
            for (int s = 0; s < SRCS; s++)
                if (wr_map && (rbus_wr_data_i[SRC_W-1:0] == SRC_W'(s)))
                    map_q[s] <= rbus_wr_data_i[16 +: ID_W];
        end
    end

endmodule

// File: tb/tb_hive_irq_router.sv
// Scoreboard bench for hive_irq_router: expected xsr/ovf/tmo events are queued at stimulus time and matched against a negedge monitor.
module tb_hive_irq_router;

    localparam logic [7:0] ADDR     = 8'h20;
    localparam logic [7:0] ADDR_MAP = 8'h21;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] src_i;
    logic [7:0]  xsr_o;
    logic [15:0] ovf_o;
    logic [7:0]  tmo_o;
    logic [2:0]  id_i;
    logic        clt_i, irt_i;
    logic [7:0]  rbus_addr_i;
    logic        rbus_wr_i, rbus_rd_i;
    logic [31:0] rbus_wr_data_i, rbus_rd_data_o;

    hive_irq_router #(.TMO_W(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .src_i(src_i), .xsr_o(xsr_o), .ovf_o(ovf_o), .tmo_o(tmo_o),
        .id_i(id_i), .clt_i(clt_i), .irt_i(irt_i), .rbus_addr_i(rbus_addr_i), .rbus_wr_i(rbus_wr_i),
        .rbus_rd_i(rbus_rd_i), .rbus_wr_data_i(rbus_wr_data_i), .rbus_rd_data_o(rbus_rd_data_o)
    );

    always #10 clk = ~clk;

    // kind: 0 = xsr, 1 = ovf, 2 = tmo
    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  idx;
        logic [31:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t e, o;
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int t = 0; t < 8; t++)  if (xsr_o[t] === 1'b1) obs_q.push_back({2'd0, 8'(t), cyc});
        for (int s = 0; s < 16; s++) if (ovf_o[s] === 1'b1) obs_q.push_back({2'd1, 8'(s), cyc});
        for (int t = 0; t < 8; t++)  if (tmo_o[t] === 1'b1) obs_q.push_back({2'd2, 8'(t), cyc});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; src_i = '0; id_i = '0; clt_i = 1'b0; irt_i = 1'b0;
        rbus_addr_i = '0; rbus_wr_i = 1'b0; rbus_rd_i = 1'b0; rbus_wr_data_i = '0;
        tick(2);
        rst_i = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic rbus_write(input logic [7:0] a, input logic [31:0] d);
        rbus_addr_i = a; rbus_wr_data_i = d; rbus_wr_i = 1'b1;
        tick(1);
        rbus_wr_i = 1'b0;
    endtask

    task automatic rbus_read(input logic [7:0] a, input logic rd, output logic [31:0] d);
        rbus_addr_i = a; rbus_rd_i = rd;
        #1;
        d = rbus_rd_data_o;
        rbus_rd_i = 1'b0;
    endtask

    task automatic pulse_src(input logic [15:0] m);
        src_i = m;
        tick(1);
        src_i = '0;
        tick(1);
    endtask

    task automatic do_irt(input logic [2:0] t);
        id_i = t; irt_i = 1'b1;
        tick(1);
        irt_i = 1'b0;
    endtask

    task automatic do_clt(input logic [2:0] t);
        id_i = t; clt_i = 1'b1;
        tick(1);
        clt_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        n_checks++;
        if ({xsr_o, ovf_o, tmo_o} !== 32'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h, expected 0", {xsr_o, ovf_o, tmo_o});
        end
        rbus_read(ADDR, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_en: got %h, expected 0", d); end
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h, expected 0", d); end
    endtask

    task automatic test_single();
        int n, m;
        logic [31:0] d;
        do_reset();
        rbus_write(ADDR, 32'h1);
        n = cyc;
        src_i = 16'h1;
        tick(1);
        src_i = '0;
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL single_pend_set: got %h, expected 1", d); end
        tick(1);
        exp_q.push_back({2'd0, 8'd0, n + 2});
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL single_pend_clear: got %h, expected 0", d); end
        n_checks++;
        if (xsr_o !== 8'h01) begin n_fail++; $display("FAIL single_xsr_now: got %h, expected 01", xsr_o); end
        tick(3);
        do_irt(3'd0);
        m = cyc;
        pulse_src(16'h1);
        exp_q.push_back({2'd0, 8'd0, m + 2});
        tick(2);
        do_irt(3'd0);
        tick(3);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL single_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL single_event: got k%0d i%0d c%0d, expected k%0d i%0d c%0d", o.kind, o.idx, o.cyc, e.kind, e.idx, e.cyc);
            end
        end
    endtask

    task automatic test_rr_block();
        int n, m, k, j;
        logic [31:0] d;
        do_reset();
        rbus_write(ADDR_MAP, 32'h0001_0001);
        rbus_write(ADDR_MAP, 32'h0001_0009);
        rbus_write(ADDR, 32'h0202);
        n = cyc;
        pulse_src(16'h0202);
        exp_q.push_back({2'd0, 8'd1, n + 2});
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0200) begin n_fail++; $display("FAIL rr_first_src1: pend %h, expected 0200", d); end
        tick(6);
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0200) begin n_fail++; $display("FAIL rr_blocked: pend %h, expected 0200", d); end
        m = cyc;
        do_irt(3'd1);
        exp_q.push_back({2'd0, 8'd1, m + 2});
        tick(1);
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rr_src9_granted: pend %h, expected 0", d); end
        tick(2);
        do_irt(3'd1);
        // rr[1] is now 10, so src 11 must beat src 9
        rbus_write(ADDR_MAP, 32'h0001_000B);
        rbus_write(ADDR, 32'h0A02);
        k = cyc;
        pulse_src(16'h0A00);
        exp_q.push_back({2'd0, 8'd1, k + 2});
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0200) begin n_fail++; $display("FAIL rr_pointer10: pend %h, expected 0200", d); end
        tick(2);
        j = cyc;
        do_irt(3'd1);
        exp_q.push_back({2'd0, 8'd1, j + 2});
        tick(3);
        do_irt(3'd1);
        tick(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rr_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL rr_event: got k%0d i%0d c%0d, expected k%0d i%0d c%0d", o.kind, o.idx, o.cyc, e.kind, e.idx, e.cyc);
            end
        end
    endtask

    task automatic test_overflow();
        int n;
        logic [31:0] d;
        do_reset();
        rbus_write(ADDR, 32'h0008);
        n = cyc;
        pulse_src(16'h0008);
        exp_q.push_back({2'd0, 8'd3, n + 2});
        pulse_src(16'h0008);
        pulse_src(16'h0008);
        exp_q.push_back({2'd1, 8'd3, n + 5});
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0008) begin n_fail++; $display("FAIL ovf_pend: got %h, expected 0008", d); end
        do_irt(3'd3);
        exp_q.push_back({2'd0, 8'd3, n + 8});
        tick(3);
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL ovf_pend_drained: got %h, expected 0", d); end
        do_irt(3'd3);
        tick(4);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ovf_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL ovf_event: got k%0d i%0d c%0d, expected k%0d i%0d c%0d", o.kind, o.idx, o.cyc, e.kind, e.idx, e.cyc);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        rbus_write(ADDR, 32'h0404);
        n = cyc;
        pulse_src(16'h0004);
        exp_q.push_back({2'd0, 8'd2, n + 2});
        pulse_src(16'h0400);
        tick(13);
        n_checks++;
        if (tmo_o !== 8'h00) begin n_fail++; $display("FAIL tmo_early: got %h, expected 00", tmo_o); end
        tick(1);
        exp_q.push_back({2'd2, 8'd2, n + 18});
        n_checks++;
        if (tmo_o !== 8'h04) begin n_fail++; $display("FAIL tmo_pulse: got %h, expected 04", tmo_o); end
        tick(2);
        exp_q.push_back({2'd0, 8'd2, n + 20});
        n_checks++;
        if (xsr_o !== 8'h04) begin n_fail++; $display("FAIL tmo_next_issue: got %h, expected 04", xsr_o); end
        tick(1);
        do_irt(3'd2);
        tick(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL tmo_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL tmo_event: got k%0d i%0d c%0d, expected k%0d i%0d c%0d", o.kind, o.idx, o.cyc, e.kind, e.idx, e.cyc);
            end
        end
    endtask

    task automatic test_disable();
        int n;
        logic [31:0] d;
        do_reset();
        rbus_write(ADDR, 32'hFFFF_0020);
        n = cyc;
        pulse_src(16'h0020);
        exp_q.push_back({2'd0, 8'd5, n + 2});
        pulse_src(16'h0020);
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0020) begin n_fail++; $display("FAIL dis_pend_set: got %h, expected 0020", d); end
        rbus_read(ADDR, 1'b1, d);
        n_checks++;
        if (d !== 32'h0020) begin n_fail++; $display("FAIL dis_en_read: got %h, expected 0020", d); end
        rbus_write(ADDR, 32'h0);
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL dis_pend_cleared: got %h, expected 0", d); end
        rbus_read(ADDR, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL dis_en_zero: got %h, expected 0", d); end
        rbus_write(ADDR, 32'h0020);
        rbus_read(8'h22, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL dis_unaddressed: got %h, expected 0", d); end
        rbus_read(ADDR, 1'b0, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL dis_no_rd: got %h, expected 0", d); end
        do_irt(3'd5);
        tick(4);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL dis_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL dis_event: got k%0d i%0d c%0d, expected k%0d i%0d c%0d", o.kind, o.idx, o.cyc, e.kind, e.idx, e.cyc);
            end
        end
    endtask

    task automatic test_reset_clt();
        int n, p, q, c;
        logic [31:0] d;
        do_reset();
        rbus_write(ADDR, 32'h0040);
        n = cyc;
        pulse_src(16'h0040);
        exp_q.push_back({2'd0, 8'd6, n + 2});
        tick(1);
        // remap while thread 6 is in WAIT: the next grant goes to thread 1
        rbus_write(ADDR_MAP, 32'h0001_0006);
        p = cyc;
        pulse_src(16'h0040);
        exp_q.push_back({2'd0, 8'd1, p + 2});
        do_irt(3'd6);
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        n_checks++;
        if ({xsr_o, ovf_o, tmo_o} !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %h, expected 0", {xsr_o, ovf_o, tmo_o});
        end
        rbus_read(ADDR, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_en: got %h, expected 0", d); end
        tick(3);
        rbus_write(ADDR, 32'h0040);
        q = cyc;
        pulse_src(16'h0040);
        exp_q.push_back({2'd0, 8'd6, q + 2});
        tick(2);
        pulse_src(16'h0040);
        c = cyc;
        do_clt(3'd6);
        exp_q.push_back({2'd0, 8'd6, c + 2});
        tick(1);
        rbus_read(ADDR_MAP, 1'b1, d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL clt_regrant: pend %h, expected 0", d); end
        tick(2);
        do_irt(3'd6);
        tick(2);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rstclt_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin
                n_fail++; $display("FAIL rstclt_event: got k%0d i%0d c%0d, expected k%0d i%0d c%0d", o.kind, o.idx, o.cyc, e.kind, e.idx, e.cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_block();
        test_overflow();
        test_timeout();
        test_disable();
        test_reset_clt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
